// File: rtl/rv32_csr_pkg.sv
// Shared constants and types for the RV32 machine-mode CSR block:
// CSR indices, mstatus bit positions, interrupt cause base, mtvec modes,
// the interrupt FSM state type and a writable-index helper.
// Optional build macro: CSR_MINSTRET_EN (adds the minstret counter indices).
package rv32_csr_pkg;

   // Machine-mode CSR indices
   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

   // mstatus fields that are actually stored
   localparam int MSTATUS_MIE_BIT  = 3;
   localparam int MSTATUS_MPIE_BIT = 7;

   // Platform line i reports cause IRQ_CAUSE_BASE+i and lives at mie/mip bit IRQ_CAUSE_BASE+i
   localparam int IRQ_CAUSE_BASE = 16;

   // mtvec[1:0] encodings; the reserved values 2 and 3 behave as direct
   localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
   localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

   // Interrupt handshake FSM
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } irq_state_e;

   // True for indices that accept writes (and therefore take the read bypass)
   function automatic logic csr_writable(input logic [11:0] idx);
      logic w;
      case (idx)
         CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
         CSR_MCYCLE, CSR_MCYCLEH: w = 1'b1;
`ifdef CSR_MINSTRET_EN
         CSR_MINSTRET, CSR_MINSTRETH: w = 1'b1;
`endif
         default: w = 1'b0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/csr_irq_arb.sv
// Highest-index-wins priority encoder over the pending interrupt lines.
// Produces a valid flag and the 5-bit cause code (IRQ_CAUSE_BASE + index).
module csr_irq_arb
   import rv32_csr_pkg::*;
#(
   parameter int NUM_IRQ = 8
) (
   input  logic [NUM_IRQ-1:0] pend_i,
   output logic               valid_o,
   output logic [4:0]         cause_o
);

   // Ascending scan so the last (highest) set line overrides lower ones
   always_comb begin
      valid_o = |pend_i;
      cause_o = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (pend_i[i]) cause_o = 5'(IRQ_CAUSE_BASE + i);
      end
   end

endmodule

// File: rtl/csr_irq_ctrl.sv
// Machine-mode CSR block with level interrupts for the RV32 core.
// Read port beside decode (combinational, with write bypass), write port
// from writeback, and a request/acknowledge interrupt handshake:
//   int_req rises when a request is latched and stays high, with int_cause
//   frozen, until the pipeline pulses int_ack; the trap CSR updates happen
//   on that same edge and int_req drops on the next cycle.
// The FSM state is visible on int_req (ST_REQ <=> int_req=1).
// Optional build macro: CSR_MINSTRET_EN adds instret_inc and minstret.
module csr_irq_ctrl
   import rv32_csr_pkg::*;
#(
   parameter int          NUM_IRQ   = 8,
   parameter logic [31:0] MTVEC_RST = 32'h2000_0064,
   parameter int          CYCLE_W   = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [11:0]        rd_idx,
   output logic [31:0]        rd_data,
   output logic               rd_illegal,
   input  logic               wb_en,
   input  logic [11:0]        wb_idx,
   input  logic [31:0]        wb_data,
   input  logic [NUM_IRQ-1:0] irq_in,
   output logic               int_req,
   output logic [4:0]         int_cause,
   input  logic               int_ack,
   input  logic [31:0]        epc_in,
   input  logic               mret_en,
   output logic [31:0]        trap_pc,
   output logic [31:0]        restore_pc,
`ifdef CSR_MINSTRET_EN
   input  logic               instret_inc,
`endif
   output logic               mie_o
);

   localparam int HI_W = CYCLE_W - 32;

   irq_state_e          state_q, state_d;
   logic [4:0]          int_cause_q, int_cause_d;
   logic                mstatus_mie_q, mstatus_mie_d;
   logic                mstatus_mpie_q, mstatus_mpie_d;
   logic [NUM_IRQ-1:0]  mie_q, mie_d;
   logic [NUM_IRQ-1:0]  mip_q, mip_d;
   logic [31:0]         mtvec_q, mtvec_d;
   logic [31:0]         mscratch_q, mscratch_d;
   logic [31:0]         mepc_q, mepc_d;
   logic [31:0]         mcause_q, mcause_d;
   logic [CYCLE_W-1:0]  mcycle_q, mcycle_d;
`ifdef CSR_MINSTRET_EN
   logic [CYCLE_W-1:0]  minstret_q, minstret_d;
`endif

   logic                arb_valid;
   logic [4:0]          arb_cause;
   logic                ack_take;
   logic [31:0]         trap_base;

   csr_irq_arb #(.NUM_IRQ(NUM_IRQ)) u_arb (
      .pend_i  (mip_q & mie_q),
      .valid_o (arb_valid),
      .cause_o (arb_cause)
   );

   // An acknowledge only counts while a request is outstanding
   assign ack_take = int_ack && (state_q == ST_REQ);

   // Interrupt FSM next state; the cause is captured only on entry to REQ
   always_comb begin
      state_d     = state_q;
      int_cause_d = int_cause_q;
      case (state_q)
         ST_IDLE: begin
            if (mstatus_mie_q && arb_valid) begin
               state_d     = ST_REQ;
               int_cause_d = arb_cause;
            end
         end
         ST_REQ: begin
            if (int_ack) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // CSR next state, applied in rising priority: CSR write, mret, trap entry
   always_comb begin
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      mie_d          = mie_q;
      mip_d          = irq_in;
      mtvec_d        = mtvec_q;
      mscratch_d     = mscratch_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      mcycle_d       = mcycle_q + CYCLE_W'(1);
`ifdef CSR_MINSTRET_EN
      minstret_d     = instret_inc ? minstret_q + CYCLE_W'(1) : minstret_q;
`endif
      if (wb_en) begin
         case (wb_idx)
            CSR_MSTATUS: begin
               mstatus_mie_d  = wb_data[MSTATUS_MIE_BIT];
               mstatus_mpie_d = wb_data[MSTATUS_MPIE_BIT];
            end
            CSR_MIE:      mie_d      = wb_data[IRQ_CAUSE_BASE +: NUM_IRQ];
            CSR_MTVEC:    mtvec_d    = wb_data;
            CSR_MSCRATCH: mscratch_d = wb_data;
            CSR_MEPC:     mepc_d     = wb_data & 32'hFFFF_FFFC;
            CSR_MCAUSE:   mcause_d   = wb_data;
            // Half writes load one half and freeze the other: no count, no carry
            CSR_MCYCLE:   mcycle_d   = {mcycle_q[CYCLE_W-1:32], wb_data};
            CSR_MCYCLEH:  mcycle_d   = {wb_data[HI_W-1:0], mcycle_q[31:0]};
`ifdef CSR_MINSTRET_EN
            CSR_MINSTRET:  minstret_d = {minstret_q[CYCLE_W-1:32], wb_data};
            CSR_MINSTRETH: minstret_d = {wb_data[HI_W-1:0], minstret_q[31:0]};
`endif
            default: ;
         endcase
      end
      if (mret_en) begin
         mstatus_mie_d  = mstatus_mpie_q;
         mstatus_mpie_d = 1'b1;
      end
      if (ack_take) begin
         mepc_d         = epc_in & 32'hFFFF_FFFC;
         mcause_d       = {1'b1, 26'b0, int_cause_q};
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
      end
   end

   // State registers; reset drops any outstanding request immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         int_cause_q    <= '0;
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_q          <= '0;
         mip_q          <= '0;
         mtvec_q        <= MTVEC_RST;
         mscratch_q     <= '0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mcycle_q       <= '0;
`ifdef CSR_MINSTRET_EN
         minstret_q     <= '0;
`endif
      end else begin
         state_q        <= state_d;
         int_cause_q    <= int_cause_d;
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mie_q          <= mie_d;
         mip_q          <= mip_d;
         mtvec_q        <= mtvec_d;
         mscratch_q     <= mscratch_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         mcycle_q       <= mcycle_d;
`ifdef CSR_MINSTRET_EN
         minstret_q     <= minstret_d;
`endif
      end
   end

   // Read mux; a same-cycle write to a writable index is forwarded
   always_comb begin
      rd_data    = '0;
      rd_illegal = 1'b0;
      case (rd_idx)
         CSR_MSTATUS: begin
            rd_data[MSTATUS_MIE_BIT]  = mstatus_mie_q;
            rd_data[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
         end
         CSR_MIE:      rd_data[IRQ_CAUSE_BASE +: NUM_IRQ] = mie_q;
         CSR_MIP:      rd_data[IRQ_CAUSE_BASE +: NUM_IRQ] = mip_q;
         CSR_MTVEC:    rd_data = mtvec_q;
         CSR_MSCRATCH: rd_data = mscratch_q;
         CSR_MEPC:     rd_data = mepc_q;
         CSR_MCAUSE:   rd_data = mcause_q;
         CSR_MCYCLE,  CSR_CYCLE:  rd_data = mcycle_q[31:0];
         CSR_MCYCLEH, CSR_CYCLEH: rd_data[HI_W-1:0] = mcycle_q[CYCLE_W-1:32];
`ifdef CSR_MINSTRET_EN
         CSR_MINSTRET,  CSR_INSTRET:  rd_data = minstret_q[31:0];
         CSR_MINSTRETH, CSR_INSTRETH: rd_data[HI_W-1:0] = minstret_q[CYCLE_W-1:32];
`endif
         default: rd_illegal = 1'b1;
      endcase
      if (wb_en && (wb_idx == rd_idx) && csr_writable(rd_idx)) rd_data = wb_data;
   end

   // Trap target: vectored mode offsets by 4*cause using the committed mcause
   always_comb begin
      trap_base = {mtvec_q[31:2], 2'b00};
      if (mtvec_q[1:0] == MTVEC_MODE_VECTORED) begin
         trap_pc = trap_base + {25'b0, mcause_q[4:0], 2'b00};
      end else begin
         trap_pc = trap_base;
      end
   end

   assign int_req    = (state_q == ST_REQ);
   assign int_cause  = int_cause_q;
   assign restore_pc = mepc_q;
   assign mie_o      = mstatus_mie_q;

endmodule

// File: tb/tb_csr_irq_ctrl.sv
// Directed bench for csr_irq_ctrl: reset values, CSR map, interrupt
// handshake and arbitration, vectored trap PC, write/ack priority,
// read bypass, mcycle half writes and the optional minstret counter.
// Inputs change on the falling edge; outputs are checked before the next
// rising edge.
module tb_csr_irq_ctrl;

   localparam int NUM_IRQ = 8;

   logic               clk;
   logic               rst_n;
   logic [11:0]        rd_idx;
   logic [31:0]        rd_data;
   logic               rd_illegal;
   logic               wb_en;
   logic [11:0]        wb_idx;
   logic [31:0]        wb_data;
   logic [NUM_IRQ-1:0] irq_in;
   logic               int_req;
   logic [4:0]         int_cause;
   logic               int_ack;
   logic [31:0]        epc_in;
   logic               mret_en;
   logic [31:0]        trap_pc;
   logic [31:0]        restore_pc;
   logic               mie_o;
`ifdef CSR_MINSTRET_EN
   logic               instret_inc;
`endif

   int n_total = 0;
   int n_pass  = 0;

   csr_irq_ctrl #(
      .NUM_IRQ   (NUM_IRQ),
      .MTVEC_RST (32'h2000_0064),
      .CYCLE_W   (64)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_idx     (rd_idx),
      .rd_data    (rd_data),
      .rd_illegal (rd_illegal),
      .wb_en      (wb_en),
      .wb_idx     (wb_idx),
      .wb_data    (wb_data),
      .irq_in     (irq_in),
      .int_req    (int_req),
      .int_cause  (int_cause),
      .int_ack    (int_ack),
      .epc_in     (epc_in),
      .mret_en    (mret_en),
      .trap_pc    (trap_pc),
      .restore_pc (restore_pc),
`ifdef CSR_MINSTRET_EN
      .instret_inc(instret_inc),
`endif
      .mie_o      (mie_o)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Called on a falling edge; the write lands on the following rising edge
   task automatic write_csr(input logic [11:0] idx, input logic [31:0] data);
      wb_en   = 1'b1;
      wb_idx  = idx;
      wb_data = data;
      @(negedge clk);
      wb_en   = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [11:0] idx, input logic [31:0] exp);
      rd_idx = idx;
      #1;
      check(tag, rd_data, exp);
   endtask

   // Bounded wait for int_req; an expired budget shows up as a failed check
   task automatic wait_req(input string tag, input int max_cyc);
      for (int i = 0; i < max_cyc && !int_req; i++) @(negedge clk);
      check(tag, 32'(int_req), 32'd1);
   endtask

   initial begin
      rst_n   = 1'b0;
      rd_idx  = '0;
      wb_en   = 1'b0;
      wb_idx  = '0;
      wb_data = '0;
      irq_in  = '0;
      int_ack = 1'b0;
      epc_in  = '0;
      mret_en = 1'b0;
`ifdef CSR_MINSTRET_EN
      instret_inc = 1'b0;
`endif

      // ---- reset state
      repeat (2) @(negedge clk);
      check("rst int_req", 32'(int_req), 32'd0);
      check("rst int_cause", 32'(int_cause), 32'd0);
      read_check("rst mtvec", 12'h305, 32'h2000_0064);
      read_check("rst mstatus", 12'h300, 32'h0);
      read_check("rst mcycle", 12'hB00, 32'h0);
      read_check("illegal rd_data", 12'h7C0, 32'h0);
      check("illegal flag", 32'(rd_illegal), 32'd1);
      rd_idx = 12'h344;
      #1 check("mip legal flag", 32'(rd_illegal), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ---- single interrupt, held request, acknowledge
      write_csr(12'h304, 32'h0001_0000);
      write_csr(12'h300, 32'h0000_0008);
      check("mie_o set", 32'(mie_o), 32'd1);
      irq_in = 8'h01;
      @(negedge clk);
      irq_in = 8'h00;
      check("req after 1 cyc", 32'(int_req), 32'd0);
      read_check("mip captured", 12'h344, 32'h0001_0000);
      @(negedge clk);
      check("req after 2 cyc", 32'(int_req), 32'd1);
      check("cause line0", 32'(int_cause), 32'd16);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("req held", {27'b0, int_req, int_cause[3:0]}, {27'b0, 1'b1, 4'h0});
      end
      int_ack = 1'b1;
      epc_in  = 32'h2000_0103;
      @(negedge clk);
      int_ack = 1'b0;
      check("req dropped", 32'(int_req), 32'd0);
      read_check("mepc after ack", 12'h341, 32'h2000_0100);
      check("restore_pc", restore_pc, 32'h2000_0100);
      read_check("mcause after ack", 12'h342, 32'h8000_0010);
      read_check("mstatus after ack", 12'h300, 32'h0000_0080);

      // ---- two lines: highest wins; mret re-enables and line 0 retriggers
      write_csr(12'h304, 32'h0009_0000);
      irq_in = 8'h09;
      write_csr(12'h300, 32'h0000_0088);
      check("no req before MIE", 32'(int_req), 32'd0);
      @(negedge clk);
      check("req two lines", 32'(int_req), 32'd1);
      check("cause highest", 32'(int_cause), 32'd19);
      int_ack = 1'b1;
      epc_in  = 32'h0000_0040;
      irq_in  = 8'h01;
      @(negedge clk);
      int_ack = 1'b0;
      check("idle after ack2", 32'(int_req), 32'd0);
      read_check("mcause 19", 12'h342, 32'h8000_0013);
      check("mie_o cleared", 32'(mie_o), 32'd0);
      mret_en = 1'b1;
      @(negedge clk);
      mret_en = 1'b0;
      check("mret MIE", 32'(mie_o), 32'd1);
      read_check("mret mstatus", 12'h300, 32'h0000_0088);
      check("no req same cyc", 32'(int_req), 32'd0);
      @(negedge clk);
      check("req after mret", 32'(int_req), 32'd1);
      check("cause after mret", 32'(int_cause), 32'd16);
      int_ack = 1'b1;
      epc_in  = 32'h0;
      irq_in  = 8'h00;
      @(negedge clk);
      int_ack = 1'b0;

      // ---- vectored mtvec
      write_csr(12'h305, 32'h2000_0001);
      write_csr(12'h304, 32'h0004_0000);
      irq_in = 8'h04;
      write_csr(12'h300, 32'h0000_0008);
      wait_req("req line2", 10);
      check("cause line2", 32'(int_cause), 32'd18);
      check("trap_pc old cause", trap_pc, 32'h2000_0040);
      int_ack = 1'b1;
      irq_in  = 8'h00;
      @(negedge clk);
      int_ack = 1'b0;
      check("trap_pc vectored", trap_pc, 32'h2000_0048);
      write_csr(12'h305, 32'h2000_0000);
      check("trap_pc direct", trap_pc, 32'h2000_0000);
      write_csr(12'h305, 32'h2000_0003);
      check("trap_pc mode3", trap_pc, 32'h2000_0000);
      read_check("mtvec readback", 12'h305, 32'h2000_0003);

      // ---- same-edge write vs ack, bypass
      write_csr(12'h304, 32'h0002_0000);
      irq_in = 8'h02;
      write_csr(12'h300, 32'h0000_0008);
      wait_req("req line1", 10);
      check("cause line1", 32'(int_cause), 32'd17);
      int_ack = 1'b1;
      epc_in  = 32'h0000_0010;
      irq_in  = 8'h00;
      wb_en   = 1'b1;
      wb_idx  = 12'h341;
      wb_data = 32'h1234_0000;
      read_check("bypass mepc", 12'h341, 32'h1234_0000);
      @(negedge clk);
      int_ack = 1'b0;
      wb_en   = 1'b0;
      read_check("ack beats write", 12'h341, 32'h0000_0010);
      read_check("mcause 17", 12'h342, 32'h8000_0011);
      read_check("mstatus ack3", 12'h300, 32'h0000_0080);

      // read-only index: no bypass, write ignored
      wb_en   = 1'b1;
      wb_idx  = 12'h344;
      wb_data = 32'hFFFF_FFFF;
      read_check("no bypass mip", 12'h344, 32'h0);
      @(negedge clk);
      wb_en = 1'b0;
      read_check("mip unwritten", 12'h344, 32'h0);

      // ack while idle is ignored
      int_ack = 1'b1;
      epc_in  = 32'h0000_0ABC;
      @(negedge clk);
      int_ack = 1'b0;
      read_check("idle ack mepc", 12'h341, 32'h0000_0010);
      read_check("idle ack mcause", 12'h342, 32'h8000_0011);
      check("idle ack req", 32'(int_req), 32'd0);

      // field masking
      write_csr(12'h340, 32'hDEAD_BEEF);
      read_check("mscratch", 12'h340, 32'hDEAD_BEEF);
      write_csr(12'h304, 32'hFFFF_FFFF);
      read_check("mie mask", 12'h304, 32'h00FF_0000);
      write_csr(12'h300, 32'hFFFF_FFFF);
      read_check("mstatus mask", 12'h300, 32'h0000_0088);
      write_csr(12'h300, 32'h0);
      write_csr(12'h341, 32'h0000_0107);
      read_check("mepc low bits", 12'h341, 32'h0000_0104);

      // ---- mcycle half writes
      wb_en   = 1'b1;
      wb_idx  = 12'hB80;
      wb_data = 32'h0000_0005;
      @(negedge clk);
      wb_idx  = 12'hB00;
      wb_data = 32'hFFFF_FFFF;
      @(negedge clk);
      wb_en = 1'b0;
      read_check("mcycle lo loaded", 12'hB00, 32'hFFFF_FFFF);
      read_check("mcycle hi held", 12'hB80, 32'h0000_0005);
      read_check("cycleh alias", 12'hC80, 32'h0000_0005);
      @(negedge clk);
      read_check("mcycle lo wrap", 12'hB00, 32'h0);
      read_check("mcycle hi carry", 12'hB80, 32'h0000_0006);
      read_check("cycle alias", 12'hC00, 32'h0);
      write_csr(12'hC80, 32'h0000_1234);
      read_check("alias read-only", 12'hB80, 32'h0000_0006);

      // ---- optional minstret
`ifdef CSR_MINSTRET_EN
      read_check("instret rst", 12'hC02, 32'h0);
      instret_inc = 1'b1;
      repeat (3) @(negedge clk);
      instret_inc = 1'b0;
      @(negedge clk);
      read_check("instret 3", 12'hC02, 32'h0000_0003);
      check("instret legal", 32'(rd_illegal), 32'd0);
      read_check("minstret 3", 12'hB02, 32'h0000_0003);
      read_check("instreth 0", 12'hC82, 32'h0);
`else
      read_check("B02 reads 0", 12'hB02, 32'h0);
      check("B02 illegal", 32'(rd_illegal), 32'd1);
      read_check("C02 reads 0", 12'hC02, 32'h0);
      check("C02 illegal", 32'(rd_illegal), 32'd1);
      rd_idx = 12'hB82;
      #1 check("B82 illegal", 32'(rd_illegal), 32'd1);
      rd_idx = 12'hC82;
      #1 check("C82 illegal", 32'(rd_illegal), 32'd1);
`endif
      @(negedge clk);

      // ---- reset asserted while a request is pending
      write_csr(12'h304, 32'h0001_0000);
      irq_in = 8'h01;
      write_csr(12'h300, 32'h0000_0008);
      wait_req("req before reset", 10);
      #2 rst_n = 1'b0;
      #1;
      check("reset drops req", 32'(int_req), 32'd0);
      check("reset cause", 32'(int_cause), 32'd0);
      check("reset mepc", restore_pc, 32'h0);
      read_check("reset mtvec", 12'h305, 32'h2000_0064);
      irq_in = 8'h00;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
